// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU memory strobes and the responder.
// slave = responder side, master = requester side.
interface mem_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;
  logic              ovr;

  modport slave (
    input  read, write, addr, wdata,
    output rdata, ready, busy, err, ovr
  );

  modport master (
    output read, write, addr, wdata,
    input  rdata, ready, busy, err, ovr
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder: one request at a time, WAIT wait states, then a
// one-cycle ready pulse; all outputs registered, strobes outside IDLE only flag ovr.
module mem_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int WAIT   = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAITS, RESP} state_t;

  localparam int CNT_INIT = (WAIT > 0) ? WAIT - 1 : 0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;

  logic              acc;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acc       = 1'b0;
    acc_wr    = op_wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.read ^ bus.write) begin
          op_wr_d = bus.write;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          // With no wait states the access edge is the request edge itself,
          // so the array sees the live request rather than the captured copy.
          if (WAIT == 0) begin
            state_d   = RESP;
            acc       = 1'b1;
            acc_wr    = bus.write;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
          end else begin
            state_d = WAITS;
            cnt_d   = CNT_INIT[3:0];
          end
        end
      end
      WAITS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          acc     = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rdata_d = rdata_q;
    if (acc && !acc_wr) begin
      rdata_d = mem_q[acc_addr];
    end
    ready_d = acc;
    busy_d  = (state_d != IDLE);
    err_d   = (state_q == IDLE) && bus.read && bus.write;
    ovr_d   = ovr_q || ((state_q != IDLE) && (bus.read || bus.write));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  // Array is not reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && acc && acc_wr) begin
      mem_q[acc_addr] <= acc_wdata;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
  assign bus.ovr   = ovr_q;

endmodule
